// File: rtl/btb_pkg.sv
// Shared types, default sizes and PC field helpers for the 2-way branch target buffer.
package btb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int SETS_DEF   = 8;
    localparam int IDX_W_DEF  = $clog2(SETS_DEF);
    localparam int TAG_W_DEF  = ADDR_W_DEF - 1 - IDX_W_DEF;

    // Wide all-ones constant; users cast it down to their target width.
    localparam logic [63:0] RESET_TARGET = '1;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W_DEF-1:0]  tag;
        logic [ADDR_W_DEF-1:0] target;
    } btb_entry_t;

    function automatic logic [31:0] idx_of(input logic [31:0] pc, input int idx_w);
        return (pc >> 1) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 1);
    endfunction

endpackage

// File: rtl/btb_set.sv
// One BTB set: two entries plus an LRU bit; combinational lookup, registered update.
module btb_set
    import btb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lkp_en,
    input  logic [TAG_W-1:0]  lkp_tag,
    output logic              lkp_hit,
    output logic [ADDR_W-1:0] lkp_target,
    input  logic              upd_en,
    input  logic [TAG_W-1:0]  upd_tag,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target
);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
    } entry_t;

    entry_t way_q [2];
    logic   lru_q;

    logic [1:0] lkp_match, upd_match;
    logic       lkp_way, upd_way, upd_hit, victim;

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            lkp_match[w] = way_q[w].valid && (way_q[w].tag == lkp_tag);
            upd_match[w] = way_q[w].valid && (way_q[w].tag == upd_tag);
        end
        lkp_way    = lkp_match[1] & ~lkp_match[0];
        lkp_hit    = |lkp_match;
        lkp_target = way_q[lkp_way].target;
        upd_way    = upd_match[1] & ~upd_match[0];
        upd_hit    = |upd_match;
        // Fill an empty way first, way0 preferred; only evict when both are live.
        if (!way_q[0].valid)      victim = 1'b0;
        else if (!way_q[1].valid) victim = 1'b1;
        else                      victim = lru_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 2; w++) begin
                way_q[w].valid  <= 1'b0;
                way_q[w].tag    <= '0;
                way_q[w].target <= ADDR_W'(RESET_TARGET);
            end
            lru_q <= 1'b0;
        end else begin
            // Lookup touch first so a same-cycle update wins the LRU bit.
            if (lkp_en && lkp_hit) lru_q <= ~lkp_way;
            if (upd_en) begin
                if (upd_taken && upd_hit) begin
                    way_q[upd_way].target <= upd_target;
                    lru_q                 <= ~upd_way;
                end else if (upd_taken) begin
                    way_q[victim] <= '{valid: 1'b1, tag: upd_tag, target: upd_target};
                    lru_q         <= ~victim;
                end else if (upd_hit) begin
                    way_q[upd_way].valid <= 1'b0;
                    lru_q                <= upd_way;
                end
            end
        end
    end

endmodule

// File: rtl/btb_array.sv
// 2-way set-associative BTB: set decode, registered lookup response, optional
// same-cycle update forwarding when BTB_BYPASS_EN is defined.
module btb_array
    import btb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SETS   = SETS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lkp_valid,
    input  logic [ADDR_W-1:0] lkp_pc,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 1 - IDX_W;

    logic [IDX_W-1:0]  lkp_idx, upd_idx;
    logic [TAG_W-1:0]  lkp_tag, upd_tag;
    logic [SETS-1:0]   set_hit;
    logic [ADDR_W-1:0] set_target [SETS];

    assign lkp_idx = IDX_W'(idx_of(32'(lkp_pc), IDX_W));
    assign lkp_tag = TAG_W'(tag_of(32'(lkp_pc), IDX_W));
    assign upd_idx = IDX_W'(idx_of(32'(upd_pc), IDX_W));
    assign upd_tag = TAG_W'(tag_of(32'(upd_pc), IDX_W));

    for (genvar s = 0; s < SETS; s++) begin : g_set
        btb_set #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) u_set (
            .clk        (clk),
            .rst        (rst),
            .lkp_en     (lkp_valid && (lkp_idx == IDX_W'(s))),
            .lkp_tag    (lkp_tag),
            .lkp_hit    (set_hit[s]),
            .lkp_target (set_target[s]),
            .upd_en     (upd_valid && (upd_idx == IDX_W'(s))),
            .upd_tag    (upd_tag),
            .upd_taken  (upd_taken),
            .upd_target (upd_target)
        );
    end

    // Stage p0: select the indexed set and form the next response.
    logic              hit_p0;
    logic [ADDR_W-1:0] target_p0;

    always_comb begin
        hit_p0    = set_hit[lkp_idx];
        target_p0 = hit_p0 ? set_target[lkp_idx] : ADDR_W'(RESET_TARGET);
`ifdef BTB_BYPASS_EN
        if (upd_valid && (upd_idx == lkp_idx) && (upd_tag == lkp_tag)) begin
            hit_p0    = upd_taken;
            target_p0 = upd_taken ? upd_target : ADDR_W'(RESET_TARGET);
        end
`endif
    end

    // Stage p1: registered response.
    logic              vld_p1, hit_p1;
    logic [ADDR_W-1:0] target_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            hit_p1    <= 1'b0;
            target_p1 <= ADDR_W'(RESET_TARGET);
        end else if (lkp_valid) begin
            vld_p1    <= 1'b1;
            hit_p1    <= hit_p0;
            target_p1 <= target_p0;
        end else begin
            vld_p1 <= 1'b0;
            hit_p1 <= 1'b0;
        end
    end

    assign rsp_valid  = vld_p1;
    assign rsp_hit    = hit_p1;
    assign rsp_target = target_p1;

endmodule

// File: tb/tb_btb_array.sv
// Scoreboard bench for btb_array: lookups push expected responses, a negedge monitor checks them.
module tb_btb_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        lkp_valid;
    logic [15:0] lkp_pc;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [15:0] rsp_target;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;

    int errors = 0;
    int checks = 0;

    logic [16:0] exp_q [$];
    string       name_q [$];

    always #5 clk = ~clk;

    btb_array #(.ADDR_W(16), .SETS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .lkp_valid  (lkp_valid),
        .lkp_pc     (lkp_pc),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_target (rsp_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every presented response is matched against the oldest expectation.
    logic [16:0] mon_e;
    string       mon_n;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got hit=%0b tgt=%0h expected no response", rsp_hit, rsp_target);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                chk({mon_n, "_hit"}, 32'(rsp_hit), 32'(mon_e[16]));
                chk({mon_n, "_tgt"}, 32'(rsp_target), 32'(mon_e[15:0]));
            end
        end
    end

    task automatic step(input logic lv, input logic [15:0] lpc,
                        input logic uv, input logic [15:0] upc, input logic ut, input logic [15:0] utgt,
                        input logic eh, input logic [15:0] et, input string nm);
        lkp_valid  = lv;
        lkp_pc     = lpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        if (lv && !rst) begin
            exp_q.push_back({eh, et});
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        lkp_valid = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic lk(input logic [15:0] pc, input logic eh, input logic [15:0] et, input string nm);
        step(1'b1, pc, 1'b0, 16'h0, 1'b0, 16'h0, eh, et, nm);
    endtask

    task automatic up(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
        step(1'b0, 16'h0, 1'b1, pc, taken, tgt, 1'b0, 16'h0, "");
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, "");
    endtask

    initial begin
        rst = 1'b1;
        lkp_valid = 1'b0; lkp_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        idle();
        idle();
        rst = 1'b0;
        chk("reset_vld", 32'(rsp_valid), 32'd0);
        chk("reset_hit", 32'(rsp_hit), 32'd0);
        chk("reset_tgt", 32'(rsp_target), 32'hffff);

        // T1 / T2
        lk(16'h3000, 1'b0, 16'hffff, "t1_miss");
        up(16'h3002, 1'b1, 16'h3040);
        lk(16'h3002, 1'b1, 16'h3040, "t2_hit");

        // T4: invalidate, then a not-taken update to an absent pc in a live set
        up(16'h3002, 1'b0, 16'h0);
        lk(16'h3002, 1'b0, 16'hffff, "t4_inval");
        up(16'h3008, 1'b1, 16'h3080);
        up(16'h3018, 1'b0, 16'h0);
        lk(16'h3008, 1'b1, 16'h3080, "t4_absent");
        idle();
        chk("idle_vld", 32'(rsp_valid), 32'd0);
        chk("idle_hold_tgt", 32'(rsp_target), 32'h3080);

        // T3: LRU replacement within set 1
        rst = 1'b1;
        idle();
        rst = 1'b0;
        up(16'h3002, 1'b1, 16'h3a00);
        up(16'h3012, 1'b1, 16'h3b00);
        lk(16'h3002, 1'b1, 16'h3a00, "t3_a");
        up(16'h3022, 1'b1, 16'h3c00);
        lk(16'h3012, 1'b0, 16'hffff, "t3_evicted");
        lk(16'h3002, 1'b1, 16'h3a00, "t3_a_kept");
        lk(16'h3022, 1'b1, 16'h3c00, "t3_c");
        up(16'h3002, 1'b1, 16'h3d00);
        lk(16'h3002, 1'b1, 16'h3d00, "t3_refresh");

        // T5: same-cycle collision, then independent sets in one cycle
`ifdef BTB_BYPASS_EN
        step(1'b1, 16'h3004, 1'b1, 16'h3004, 1'b1, 16'h3100, 1'b1, 16'h3100, "t5_same");
`else
        step(1'b1, 16'h3004, 1'b1, 16'h3004, 1'b1, 16'h3100, 1'b0, 16'hffff, "t5_same");
`endif
        lk(16'h3004, 1'b1, 16'h3100, "t5_next");
        step(1'b1, 16'h3002, 1'b1, 16'h3006, 1'b1, 16'h3600, 1'b1, 16'h3d00, "diffset_lkp");
        lk(16'h3006, 1'b1, 16'h3600, "diffset_upd");

        // T6: reset overrides a concurrent lookup and update
        rst = 1'b1;
        step(1'b1, 16'h3004, 1'b1, 16'h300a, 1'b1, 16'h3aaa, 1'b0, 16'h0, "");
        rst = 1'b0;
        chk("t6_vld", 32'(rsp_valid), 32'd0);
        chk("t6_tgt", 32'(rsp_target), 32'hffff);
        lk(16'h3002, 1'b0, 16'hffff, "t6_3002");
        lk(16'h3004, 1'b0, 16'hffff, "t6_3004");
        lk(16'h3006, 1'b0, 16'hffff, "t6_3006");
        lk(16'h3022, 1'b0, 16'hffff, "t6_3022");
        lk(16'h300a, 1'b0, 16'hffff, "t6_300a");
        idle();
        idle();
        chk("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
